// File: rtl/popcount_expand19.sv
// Count-to-vector expander: sets min(in_count, WIDTH) bits, one per cycle, at stride-walked positions.
// Optional macro POPEXP_LFSR_EN seeds each transaction's start pointer from a 5-bit LFSR.
module popcount_expand19 #(
  parameter int WIDTH  = 19,
  parameter int CW     = 5,
  parameter int STRIDE = 7,
  parameter int START  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_sat,
  output logic [1:0]       dbg_state
);

  localparam int PW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // Handshake: a transfer happens on an edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in OUT, so they never overlap.

  logic [1:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_rem;
  logic [WIDTH-1:0] r_vec;
  logic             r_sat;

  logic             w_accept;
  logic             w_sat;
  logic [CW-1:0]    w_k;
  logic [PW:0]      w_sum;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW-1:0]    w_start;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_sat     = in_count > CW'(WIDTH);
  assign w_k       = w_sat ? CW'(WIDTH) : in_count;
  // Modular step without a divider: stride < WIDTH so one subtraction suffices.
  assign w_sum     = {1'b0, r_ptr} + (PW+1)'(STRIDE);
  assign w_ptr_nxt = (w_sum >= (PW+1)'(WIDTH)) ? PW'(w_sum - (PW+1)'(WIDTH)) : PW'(w_sum);

`ifdef POPEXP_LFSR_EN
  logic [4:0] r_lfsr;

  assign w_start = (32'(r_lfsr) >= WIDTH) ? PW'(r_lfsr - 5'(WIDTH)) : PW'(r_lfsr);

  // x^5 + x^3 + 1 Fibonacci LFSR; the seed is nonzero so zero is never reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 5'b00001;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[1]};
    end
  end
`else
  assign w_start = PW'(START);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(START);
      r_rem   <= '0;
      r_vec   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec <= '0;
            r_sat <= w_sat;
            r_ptr <= w_start;
            r_rem <= w_k;
            r_state <= (w_k == '0) ? S_OUT : S_FILL;
          end
        end
        S_FILL: begin
          r_vec[r_ptr] <= 1'b1;
          r_ptr <= w_ptr_nxt;
          r_rem <= r_rem - CW'(1);
          if (r_rem == CW'(1)) begin
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign out_vec   = r_vec;
  assign out_sat   = r_sat;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_popcount_expand19.sv
// Bench for popcount_expand19: directed and random counts against a stride-position model.
module tb_popcount_expand19;

  localparam int W = 19;
  localparam int STR = 7;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_count;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_vec;
  logic         out_sat;
  logic [1:0]   dbg_state;

  int n_cmp;
  int n_err;
  int m_lfsr;
  logic [W-1:0] exp_q[$];
  logic         exp_sat_q[$];
  logic [W-1:0] last_vec;
  logic         last_sat;

  popcount_expand19 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_sat   (out_sat),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: k ones at start, start+STR, start+2*STR, ... (mod W)
  function automatic logic [W-1:0] model_vec(input int start, input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[(start + i * STR) % W] = 1'b1;
    return v;
  endfunction

  function automatic int next_start();
    int s;
`ifdef POPEXP_LFSR_EN
    s = (m_lfsr >= W) ? m_lfsr - W : m_lfsr;
    m_lfsr = ((m_lfsr << 1) & 31) | (((m_lfsr >> 4) ^ (m_lfsr >> 1)) & 1);
`else
    s = 0;
`endif
    return s;
  endfunction

  // driver: one transaction, optionally holding out_ready low for `hold` cycles
  task automatic txn(input int cnt, input int hold);
    int k;
    int lat;
    int s;
    logic [W-1:0] ev;
    logic         es;
    k = (cnt > W) ? W : cnt;
    s = next_start();
    exp_q.push_back(model_vec(s, k));
    exp_sat_q.push_back(cnt > W);
    out_ready = (hold == 0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_count = 5'(cnt);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_count = 5'($urandom_range(0, 31));
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(k + 1));
    last_vec = out_vec;
    last_sat = out_sat;
    ev = exp_q.pop_front();
    es = exp_sat_q.pop_front();
    chk("vec", 32'(out_vec), 32'(ev));
    chk("sat", 32'(out_sat), 32'(es));
    chk("popcount", 32'($countones(out_vec)), 32'(k));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_count = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_vec", 32'(out_vec), 32'(last_vec));
      chk("hold_sat", 32'(out_sat), 32'(last_sat));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_vec_kept", 32'(out_vec), 32'(last_vec));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_lfsr = 1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_vec", 32'(out_vec), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef POPEXP_LFSR_EN
    txn(1, 0); chk("lfsr_1", 32'(last_vec), 32'h00002);
    txn(1, 0); chk("lfsr_2", 32'(last_vec), 32'h00004);
    txn(1, 0); chk("lfsr_3", 32'(last_vec), 32'h00020);
`endif
    txn(3, 0);
`ifndef POPEXP_LFSR_EN
    chk("lit_c3", 32'(last_vec), 32'h04081);
`endif
    txn(19, 0);
    chk("lit_c19", 32'(last_vec), 32'h7FFFF);
    chk("lit_c19_sat", 32'(last_sat), 32'd0);
    txn(25, 0);
    chk("lit_c25", 32'(last_vec), 32'h7FFFF);
    chk("lit_c25_sat", 32'(last_sat), 32'd1);
    txn(0, 0);
    chk("lit_c0", 32'(last_vec), 32'h00000);
    txn(1, 0);
`ifndef POPEXP_LFSR_EN
    chk("lit_c1", 32'(last_vec), 32'h00001);
`endif
    txn(5, 10);
`ifndef POPEXP_LFSR_EN
    chk("lit_c5", 32'(last_vec), 32'h04285);
`endif

    // reset in the middle of a count-10 fill
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_count = 5'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_lfsr = 1;
    #1;
    chk("midrst_vec", 32'(out_vec), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(2, 0);
`ifndef POPEXP_LFSR_EN
    chk("lit_c2", 32'(last_vec), 32'h00081);
`endif

    for (int r = 0; r < 24; r++) begin
      txn($urandom_range(0, 31), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
